sd_nios2_ocimem_arbiter: RTL and testbench

SD_NIOS2_OCIMEM_ARBITER -- requirements
Module: sd_nios2_ocimem_arbiter

---
 rtl/sd_nios2_ocimem_pkg.sv | 22 ++
 rtl/sd_nios2_ocimem_jtag_hold.sv | 55 +++++
 rtl/sd_nios2_ocimem_arbiter.sv | 151 +++++++++++++++
 tb/tb_sd_nios2_ocimem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_nios2_ocimem_pkg.sv
// Shared types for the OCI RAM arbiter: FSM state encoding, default widths and the
// JTAG holding-register entry layout.
package sd_nios2_ocimem_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StAccJ,
    StAccA,
    StRdJ,
    StRdA
  } ocimem_state_e;

  typedef struct packed {
    logic                wr;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
  } hold_entry_t;

endpackage

// File: rtl/sd_nios2_ocimem_jtag_hold.sv
// One-entry holding register for JTAG-side OCI RAM requests, with a sticky
// overflow flag for requests that arrive while the entry is still occupied.
module sd_nios2_ocimem_jtag_hold
  import sd_nios2_ocimem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  hold_entry_t req_entry_i,
  input  logic        consume_i,
  input  logic        overflow_clr_i,
  output logic        full_o,
  output hold_entry_t entry_o,
  output logic        overflow_o
);

  logic        full_q, full_d;
  logic        ovf_q, ovf_d;
  hold_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    ovf_d   = ovf_q & ~overflow_clr_i;
    if (consume_i) begin
      full_d = 1'b0;
    end
    // A slot freed this cycle can take the new request; otherwise it is lost.
    if (req_i) begin
      if (!full_q || consume_i) begin
        full_d  = 1'b1;
        entry_d = req_entry_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign full_o     = full_q;
  assign entry_o    = entry_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sd_nios2_ocimem_arbiter.sv
// Arbitrates a single-ported OCI RAM between a JTAG request path and an Avalon-MM slave.
// Define OCIMEM_ARB_RR_EN for round-robin contention; otherwise JTAG has fixed priority.
module sd_nios2_ocimem_arbiter
  import sd_nios2_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rdata_valid,
  output logic              jtag_busy,
  output logic              jtag_overflow,
  input  logic              jtag_overflow_clr,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  ocimem_state_e state_q, state_d;
  hold_entry_t   hold_in, hold_entry;
  logic          hold_full, consume, a_req, j_pend, grant_j;
  logic [DATA_W-1:0] avs_rdata_q, avs_rdata_d, jtag_rdata_q, jtag_rdata_d;
  logic              avs_rdv_q, avs_rdv_d, jtag_rdv_q, jtag_rdv_d;

  always_comb begin
    hold_in       = '0;
    hold_in.wr    = jtag_wr;
    hold_in.addr  = DefAddrW'(jtag_addr);
    hold_in.wdata = DefDataW'(jtag_wdata);
  end

  sd_nios2_ocimem_jtag_hold u_jtag_hold (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_i          (jtag_req),
    .req_entry_i    (hold_in),
    .consume_i      (consume),
    .overflow_clr_i (jtag_overflow_clr),
    .full_o         (hold_full),
    .entry_o        (hold_entry),
    .overflow_o     (jtag_overflow)
  );

  assign a_req = avs_read | avs_write;
  // A strobe arriving in IDLE is latched at this edge, so ACC_J can serve it directly.
  assign j_pend = hold_full | jtag_req;

`ifdef OCIMEM_ARB_RR_EN
  logic last_j_q, last_j_d;

  always_comb begin
    last_j_d = last_j_q;
    if (state_q == StIdle && state_d == StAccJ) last_j_d = 1'b1;
    if (state_q == StIdle && state_d == StAccA) last_j_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_j_q <= 1'b0;
    else          last_j_q <= last_j_d;
  end

  assign grant_j = ~last_j_q;
`else
  assign grant_j = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    avs_waitrequest = 1'b1;
    consume         = 1'b0;
    avs_rdata_d     = avs_rdata_q;
    avs_rdv_d       = 1'b0;
    jtag_rdata_d    = jtag_rdata_q;
    jtag_rdv_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (j_pend && (!a_req || grant_j)) state_d = StAccJ;
        else if (a_req)                    state_d = StAccA;
      end
      StAccJ: begin
        ram_addr  = ADDR_W'(hold_entry.addr);
        ram_wdata = DATA_W'(hold_entry.wdata);
        ram_we    = hold_entry.wr;
        ram_re    = ~hold_entry.wr;
        consume   = 1'b1;
        state_d   = hold_entry.wr ? StIdle : StRdJ;
      end
      StAccA: begin
        avs_waitrequest = 1'b0;
        ram_addr        = avs_address;
        ram_wdata       = avs_writedata;
        ram_we          = avs_write;
        ram_re          = ~avs_write;
        state_d         = avs_write ? StIdle : StRdA;
      end
      StRdJ: begin
        jtag_rdata_d = ram_rdata;
        jtag_rdv_d   = 1'b1;
        state_d      = StIdle;
      end
      StRdA: begin
        avs_rdata_d = ram_rdata;
        avs_rdv_d   = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      avs_rdata_q  <= '0;
      avs_rdv_q    <= 1'b0;
      jtag_rdata_q <= '0;
      jtag_rdv_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      avs_rdata_q  <= avs_rdata_d;
      avs_rdv_q    <= avs_rdv_d;
      jtag_rdata_q <= jtag_rdata_d;
      jtag_rdv_q   <= jtag_rdv_d;
    end
  end

  assign jtag_busy         = hold_full;
  assign jtag_rdata        = jtag_rdata_q;
  assign jtag_rdata_valid  = jtag_rdv_q;
  assign avs_readdata      = avs_rdata_q;
  assign avs_readdatavalid = avs_rdv_q;

endmodule

// File: tb/tb_sd_nios2_ocimem_arbiter.sv
// Directed bench for sd_nios2_ocimem_arbiter with a 1-cycle RAM model and read-data scoreboards.
module tb_sd_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jtag_req, jtag_wr, jtag_overflow_clr;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata, jtag_rdata;
  logic        jtag_rdata_valid, jtag_busy, jtag_overflow;
  logic        avs_read, avs_write, avs_waitrequest, avs_readdatavalid;
  logic [7:0]  avs_address;
  logic [31:0] avs_writedata, avs_readdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_avs[$];
  logic [31:0] exp_jtag[$];
  byte         grant_log[$];
  logic [31:0] mem[256];
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  sd_nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .jtag_req          (jtag_req),
    .jtag_wr           (jtag_wr),
    .jtag_addr         (jtag_addr),
    .jtag_wdata        (jtag_wdata),
    .jtag_rdata        (jtag_rdata),
    .jtag_rdata_valid  (jtag_rdata_valid),
    .jtag_busy         (jtag_busy),
    .jtag_overflow     (jtag_overflow),
    .jtag_overflow_clr (jtag_overflow_clr),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_address       (avs_address),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_we            (ram_we),
    .ram_re            (ram_re),
    .ram_rdata         (ram_rdata)
  );

  function automatic logic [31:0] init_val(int a);
    return (a == 'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
  endfunction

  // RAM model: read data appears one cycle after ram_re.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (avs_readdatavalid) begin
        if (exp_avs.size() == 0) chk("avs_unexpected_valid", {31'b0, avs_readdatavalid}, 32'd0);
        else chk("avs_readdata", avs_readdata, exp_avs.pop_front());
      end
      if (jtag_rdata_valid) begin
        if (exp_jtag.size() == 0) chk("jtag_unexpected_valid", {31'b0, jtag_rdata_valid}, 32'd0);
        else chk("jtag_rdata", jtag_rdata, exp_jtag.pop_front());
      end
      if (ram_we || ram_re) begin
        chk("ram_we_re_exclusive", {31'b0, ram_we & ram_re}, 32'd0);
        grant_log.push_back(avs_waitrequest ? 8'h4A : 8'h41);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic jtag_pulse(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    jtag_req = 1'b1; jtag_wr = wr; jtag_addr = addr; jtag_wdata = wdata;
    cyc(1);
    jtag_req = 1'b0;
  endtask

  // Leaves the caller in the cycle where waitrequest is low.
  task automatic wait_accept();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!avs_waitrequest) done = 1'b1;
      else cyc(1);
    end
    if (!done) chk("avs_accept_timeout", {31'b0, avs_waitrequest}, 32'd0);
  endtask

  task automatic avs_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    avs_write = wr; avs_read = ~wr; avs_address = addr; avs_writedata = wdata;
    wait_accept();
    cyc(1);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    string exp_s;
    jtag_req = 0; jtag_wr = 0; jtag_addr = 0; jtag_wdata = 0; jtag_overflow_clr = 0;
    avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0;
    cyc(3);
    chk("rst_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    chk("rst_busy", {31'b0, jtag_busy}, 32'd0);
    chk("rst_overflow", {31'b0, jtag_overflow}, 32'd0);
    chk("rst_ram_we_re", {30'b0, ram_we, ram_re}, 32'd0);
    chk("rst_avs_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Uncontended Avalon read latency.
    exp_avs.push_back(32'hDEADBEEF);
    avs_read = 1'b1; avs_address = 8'h10;
    cyc(1);
    chk("lat_waitreq_n1", {31'b0, avs_waitrequest}, 32'd0);
    chk("lat_ram_re_n1", {31'b0, ram_re}, 32'd1);
    chk("lat_ram_addr_n1", {24'b0, ram_addr}, 32'h10);
    avs_read = 1'b0;
    cyc(1);
    chk("lat_rdv_n2", {31'b0, avs_readdatavalid}, 32'd0);
    cyc(1);
    chk("lat_rdv_n3", {31'b0, avs_readdatavalid}, 32'd1);
    cyc(1);
    chk("avs_readdata_hold", avs_readdata, 32'hDEADBEEF);

    // JTAG write then read back.
    jtag_pulse(1'b1, 8'h05, 32'h12345678);
    cyc(4);
    exp_jtag.push_back(32'h12345678);
    jtag_pulse(1'b0, 8'h05, 32'h0);
    cyc(4);
    chk("jtag_rdata_hold", jtag_rdata, 32'h12345678);

    // Same-cycle contention, four rounds.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      exp_jtag.push_back(init_val(32 + i));
      exp_avs.push_back(init_val(48 + i));
      jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'(32 + i);
      avs_read = 1'b1; avs_address = 8'(48 + i);
      cyc(1);
      jtag_req = 1'b0;
      wait_accept();
      cyc(1);
      avs_read = 1'b0;
      cyc(5);
    end
`ifdef OCIMEM_ARB_RR_EN
    exp_s = "AJAJAJAJ";
`else
    exp_s = "JAJAJAJA";
`endif
    chk("grant_count", grant_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("grant_%0d", i), grant_log[i], exp_s[i]);

    // A request in the consume cycle is accepted without overflow.
    jtag_pulse(1'b1, 8'h40, 32'h11110040);
    jtag_pulse(1'b1, 8'h41, 32'h22220041);
    chk("consume_busy", {31'b0, jtag_busy}, 32'd1);
    chk("consume_no_ovf", {31'b0, jtag_overflow}, 32'd0);
    cyc(4);
    exp_jtag.push_back(32'h22220041);
    jtag_pulse(1'b0, 8'h41, 32'h0);
    cyc(4);
    exp_avs.push_back(32'h11110040);
    avs_xfer(1'b0, 8'h40, 32'h0);
    cyc(3);

    // Second JTAG request while the first is still held gets dropped.
    exp_avs.push_back(init_val('h11));
    avs_read = 1'b1; avs_address = 8'h11;
    cyc(1);
    chk("ovf_avs_accept", {31'b0, avs_waitrequest}, 32'd0);
    avs_read = 1'b0;
    jtag_pulse(1'b1, 8'h30, 32'hA5A5A5A5);
    cyc(1);
    jtag_pulse(1'b1, 8'h31, 32'h5A5A5A5A);
    chk("ovf_set", {31'b0, jtag_overflow}, 32'd1);
    cyc(5);
    chk("ovf_sticky", {31'b0, jtag_overflow}, 32'd1);
    jtag_overflow_clr = 1'b1;
    cyc(1);
    jtag_overflow_clr = 1'b0;
    chk("ovf_cleared", {31'b0, jtag_overflow}, 32'd0);
    exp_jtag.push_back(32'hA5A5A5A5);
    jtag_pulse(1'b0, 8'h30, 32'h0);
    cyc(4);
    exp_avs.push_back(init_val('h31));
    avs_xfer(1'b0, 8'h31, 32'h0);
    cyc(3);

    // Reset asserted during RD_A discards the read.
    avs_read = 1'b1; avs_address = 8'h12;
    cyc(1);
    avs_read = 1'b0;
    cyc(1);
    reset_n = 1'b0;
    #1;
    chk("midrst_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    chk("midrst_rdv", {31'b0, avs_readdatavalid}, 32'd0);
    chk("midrst_avs_readdata", avs_readdata, 32'd0);
    chk("midrst_jtag_rdata", jtag_rdata, 32'd0);
    chk("midrst_ram_re", {31'b0, ram_re}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    exp_avs.push_back(32'hDEADBEEF);
    avs_xfer(1'b0, 8'h10, 32'h0);
    cyc(4);

    chk("avs_queue_empty", exp_avs.size(), 32'd0);
    chk("jtag_queue_empty", exp_jtag.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
